// File: rtl/accum_pkg.sv
// Shared types and encodings for the accumulate-sequence engine.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_XOR  = 2'b01;
    localparam logic [1:0] MODE_MUL  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/accum_op.sv
// Per-beat term generator: add, xor or multiply, zero-extended to the accumulator width.
module accum_op
    import accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH + 5
) (
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [ACC_W-1:0] o_term
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_xor;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_xor  = i_a ^ i_b;
    assign w_prod = (2 * WIDTH)'(i_a) * (2 * WIDTH)'(i_b);

    always_comb begin
        o_term = '0;
        case (i_mode)
            MODE_ADD:  o_term = ACC_W'(w_sum);
            MODE_XOR:  o_term = ACC_W'(w_xor);
            MODE_MUL:  o_term = ACC_W'(w_prod);
            MODE_RSVD: o_term = '0;
        endcase
    end

endmodule

// File: rtl/accum_seq.sv
// Job-based accumulator: start captures mode/len, then len operand beats are folded into a sum.
module accum_seq
    import accum_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ACC_W   = 2 * WIDTH + $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             aborted,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_out_valid;
    logic             r_aborted;
    logic             r_err;

    logic [ACC_W-1:0] w_term;
    logic             w_beat;
    logic             w_last;
    logic             w_bad_job;

    accum_op #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_op (
        .i_mode (r_mode),
        .i_a    (in_a),
        .i_b    (in_b),
        .o_term (w_term)
    );

    assign in_ready  = (r_state == EXEC) && !abort;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_acc;
    assign aborted   = r_aborted;
    assign err       = r_err;

    assign w_beat    = in_valid && in_ready;
    assign w_last    = w_beat && ((r_cnt + LEN_W'(1)) == r_len);
    // Judged on the captured job, so a malformed request never opens the operand port.
    assign w_bad_job = (r_len == '0) || (r_mode == MODE_RSVD) || (r_len > LEN_W'(MAX_LEN));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = LOAD;
            LOAD: w_state_nxt = w_bad_job ? DONE : EXEC;
            EXEC: if (abort || w_last) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= MODE_ADD;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) begin
                r_mode <= mode;
                r_len  <= len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == LOAD) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + LEN_W'(1);
            r_acc <= r_acc + w_term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                LOAD: begin
                    r_out_valid <= w_bad_job;
                    r_err       <= w_bad_job;
                    r_aborted   <= 1'b0;
                end
                EXEC: begin
                    if (abort) begin
                        r_out_valid <= 1'b1;
                        r_aborted   <= 1'b1;
                    end else if (w_last) begin
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/accum_seq.md
ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter MAX_LEN, default 16, maximum beats per job.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1), width of the len port.
REQ-004 Parameter ACC_W, default 2*WIDTH+$clog2(MAX_LEN+1), accumulator and result width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  job request, sampled only in IDLE.
REQ-008 mode  input  2  operation select, sampled with start: 00 add, 01 xor, 10 mult, 11 reserved.
REQ-009 len  input  LEN_W  beat count for the job, sampled with start.
REQ-010 abort  input  1  terminate the current job early; effective only in EXEC.
REQ-011 in_valid  input  1  operand pair valid.
REQ-012 in_a, in_b  input  WIDTH  operands.
REQ-013 in_ready  output  1  operand pair accepted this cycle when in_valid is also high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 result  output  ACC_W  accumulated value.
REQ-018 aborted  output  1  qualifies result: job ended by abort.
REQ-019 err  output  1  qualifies result: len was 0, reserved mode, or len > MAX_LEN.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, EXEC, DONE; IDLE->LOAD on start, LOAD->EXEC (or LOAD->DONE on an error condition), EXEC->DONE on final beat or abort, DONE->IDLE on out_ready.
REQ-021 In IDLE, start SHALL capture mode and len into registers; start in any other state SHALL be ignored.
REQ-022 LOAD SHALL last exactly one cycle and clear the accumulator and beat counter.
REQ-023 in_ready SHALL be high only in EXEC with abort low; a beat transfers when in_valid and in_ready are both high.
REQ-024 Per beat, term = in_a+in_b (add), in_a^in_b zero-extended (xor), or in_a*in_b (mult), zero-extended to ACC_W and added to the accumulator modulo 2^ACC_W.
REQ-025 Transition EXEC->DONE SHALL occur the cycle after the len-th beat transfers; out_valid is registered, so the earliest out_valid is 3 cycles after start for len=1 with in_valid held high.
REQ-026 In DONE, out_valid, result, aborted and err SHALL remain stable until out_ready is sampled high; out_valid drops the following cycle.
REQ-027 out_valid SHALL be low in all states other than DONE.
REQ-028 abort high in EXEC SHALL move to DONE next cycle with the partial sum and aborted=1; abort coinciding with in_valid transfers no beat (abort wins).
REQ-029 len=0, mode=11, or len>MAX_LEN SHALL route LOAD->DONE with result=0, err=1, aborted=0, and no beats accepted.
REQ-030 Idle cycles (in_valid low) in EXEC SHALL not advance the counter or change the accumulator.
REQ-031 start asserted in the same cycle that DONE->IDLE occurs SHALL be ignored; a new job requires start in IDLE.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE from any state, including mid-EXEC, and discard the job.
REQ-033 After reset, in_ready=0, busy=0, out_valid=0, result=0, aborted=0, err=0, counter=0.

Structure
REQ-034 Package accum_pkg SHALL hold the state_t enum (2-bit: IDLE, LOAD, EXEC, DONE) and the mode encodings (MODE_ADD, MODE_XOR, MODE_MUL, MODE_RSVD).
REQ-035 A combinational sub-module accum_op (parameters WIDTH, ACC_W) SHALL compute the zero-extended per-beat term from mode, in_a, in_b; FSM, counter and accumulator stay in accum_seq.

Verification
REQ-036 WIDTH=8, mode=00, len=3, beats (1,2),(3,4),(5,6) back-to-back -> out_valid 5 cycles after start, result=21, aborted=0, err=0.
REQ-037 mode=10, len=16, every beat (255,255) with random in_valid gaps -> result=16*65025=1040400, counter unaffected by gaps.
REQ-038 mode=01, len=4, beats 2 accepted then abort with in_valid high -> DONE with partial xor-sum of 2 beats, aborted=1, third beat not taken.
REQ-039 len=0 and, separately, mode=11 -> out_valid 2 cycles after start, result=0, err=1, in_ready never high.
REQ-040 out_ready held low 10 cycles in DONE -> result and flags stable throughout; start pulses during busy ignored.
REQ-041 rst asserted mid-EXEC after 2 of 5 beats -> IDLE next cycle, all outputs at reset values, next job result unaffected by the discarded partial sum.
